// File: rtl/ysyx_22040237_exu_mc.sv
// ysyx_22040237_exu_mc: multi-cycle execute unit (ALU, shift-add MUL, restoring DIV/REM) with valid/ready handshakes
module ysyx_22040237_exu_mc #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] op1_jump,
  input  logic [XLEN-1:0] op2_jump,
  input  logic            inst_ebreak,
  input  logic            invalid_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] pc_jump_addr,
  output logic            ebreak_o,
  output logic            invalid_o
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          r_state;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_acc, r_rd, r_pc;
  logic [CW-1:0]   r_cnt;
  logic            r_negq, r_negr, r_valid, r_ebreak, r_invalid;
  logic [XLEN-1:0] w_min, w_m1, w_m2, w_alu, w_quick;
  logic [XLEN-1:0] w_mul_acc, w_rem, w_quo, w_fin;
  logic [XLEN:0]   w_rsh, w_diff;
  logic            w_sgn, w_s1, w_s2, w_bad, w_flag, w_div, w_dz, w_ovf, w_iter, w_qb;
  assign w_min   = {1'b1, {(XLEN-1){1'b0}}};
  assign w_sgn   = in_op == 4'd11 || in_op == 4'd13;
  assign w_s1    = w_sgn & op1[XLEN-1];
  assign w_s2    = w_sgn & op2[XLEN-1];
  assign w_m1    = w_s1 ? -op1 : op1;
  assign w_m2    = w_s2 ? -op2 : op2;
  assign w_bad   = invalid_inst || in_op == 4'd15;
  assign w_flag  = w_bad || inst_ebreak;
  assign w_div   = in_op >= 4'd11 && in_op <= 4'd14;
  assign w_dz    = op2 == '0;
  assign w_ovf   = w_sgn && op1 == w_min && &op2;
  // MUL and non-degenerate divides iterate; every other op completes on acceptance
  assign w_iter  = !w_flag && (in_op == 4'd10 || (w_div && !w_dz && !w_ovf));
  always_comb begin
    w_alu = '0;
    case (in_op)
      4'd0:    w_alu = op1 + op2;
      4'd1:    w_alu = op1 - op2;
      4'd2:    w_alu = op1 & op2;
      4'd3:    w_alu = op1 | op2;
      4'd4:    w_alu = op1 ^ op2;
      4'd5:    w_alu = op1 << op2[SHW-1:0];
      4'd6:    w_alu = op1 >> op2[SHW-1:0];
      4'd7:    w_alu = $signed(op1) >>> op2[SHW-1:0];
      4'd8:    w_alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'd9:    w_alu = {{(XLEN-1){1'b0}}, op1 < op2};
      default: w_alu = '0;
    endcase
  end
  // divide-by-zero: quotient all-ones, remainder op1; signed overflow: quotient op1, remainder 0
  assign w_quick = w_flag ? '0 :
                   (w_div && w_dz) ? ((in_op == 4'd11 || in_op == 4'd12) ? '1 : op1) :
                   (w_div && w_ovf) ? (in_op == 4'd11 ? op1 : '0) : w_alu;
  // one iteration step; for MUL r_a is the shifting multiplicand and r_b the shifting multiplier,
  // for divides r_a shifts dividend bits out of the top and quotient bits in at the bottom
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
  assign w_rsh     = {r_acc, r_a[XLEN-1]};
  assign w_diff    = w_rsh - {1'b0, r_b};
  assign w_qb      = !w_diff[XLEN];
  assign w_rem     = w_qb ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
  assign w_quo     = {r_a[XLEN-2:0], w_qb};
  assign w_fin     = r_op == 4'd10 ? w_mul_acc :
                     (r_op == 4'd11 || r_op == 4'd12) ? (r_negq ? -w_quo : w_quo) :
                     (r_negr ? -w_rem : w_rem);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_rd      <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_negq    <= 1'b0;
      r_negr    <= 1'b0;
      r_valid   <= 1'b0;
      r_ebreak  <= 1'b0;
      r_invalid <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_op      <= in_op;
          r_a       <= w_m1;
          r_b       <= w_m2;
          r_acc     <= '0;
          r_negq    <= w_s1 ^ w_s2;
          r_negr    <= w_s1;
          r_pc      <= op1_jump + op2_jump;
          r_ebreak  <= inst_ebreak;
          r_invalid <= w_bad;
          r_rd      <= w_quick;
          r_cnt     <= w_iter ? CW'(XLEN-1) : '0;
          r_state   <= w_iter ? BUSY : DONE;
          r_valid   <= !w_iter;
        end
        BUSY: begin
          r_acc <= r_op == 4'd10 ? w_mul_acc : w_rem;
          r_a   <= r_op == 4'd10 ? r_a << 1 : w_quo;
          r_b   <= r_op == 4'd10 ? r_b >> 1 : r_b;
          r_cnt <= r_cnt == '0 ? '0 : r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_rd    <= w_fin;
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready     = r_state == IDLE;
  assign out_valid    = r_valid;
  assign rd_data      = r_rd;
  assign pc_jump_addr = r_pc;
  assign ebreak_o     = r_ebreak;
  assign invalid_o    = r_invalid;
endmodule

// File: tb/tb_ysyx_22040237_exu_mc.sv
// tb_ysyx_22040237_exu_mc: directed self-checking bench for the execute unit
module tb_ysyx_22040237_exu_mc;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [63:0] op1, op2, op1_jump, op2_jump, rd_data, pc_jump_addr;
  logic        inst_ebreak, invalid_inst, ebreak_o, invalid_o;
  int n_cmp = 0;
  int n_fail = 0;
  ysyx_22040237_exu_mc #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
    .inst_ebreak(inst_ebreak), .invalid_inst(invalid_inst), .out_valid(out_valid),
    .out_ready(out_ready), .rd_data(rd_data), .pc_jump_addr(pc_jump_addr),
    .ebreak_o(ebreak_o), .invalid_o(invalid_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic eb, input logic inv);
    in_op = op; op1 = a; op2 = b; inst_ebreak = eb; invalid_inst = inv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op1 = '1; op2 = '1; inst_ebreak = 1'b0; invalid_inst = 1'b0;
  endtask
  task automatic quick(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
    issue(op, a, b, 1'b0, 1'b0);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk(tag, rd_data, exp);
    tick();
    chk({tag, "_idle"}, {63'b0, in_ready}, 64'd1);
  endtask
  task automatic long_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    issue(op, a, b, 1'b0, 1'b0);
    repeat (63) tick();
    chk({tag, "_busy"}, {62'b0, in_ready, out_valid}, 64'd0);
    tick();
    chk({tag, "_valid"}, {62'b0, in_ready, out_valid}, 64'd1);
    chk(tag, rd_data, exp);
    tick();
    chk({tag, "_idle"}, {62'b0, in_ready, out_valid}, 64'd2);
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_op = '0;
    op1 = '0; op2 = '0; op1_jump = '0; op2_jump = '0; inst_ebreak = 1'b0; invalid_inst = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_rd", rd_data, 64'd0);
    chk("rst_pc", pc_jump_addr, 64'd0);
    chk("rst_flags", {62'b0, ebreak_o, invalid_o}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    op1_jump = 64'h8000_0000; op2_jump = 64'd4;
    issue(4'd0, 64'd5, 64'd7, 1'b0, 1'b0);
    chk("add_valid", {63'b0, out_valid}, 64'd1);
    chk("add_rd", rd_data, 64'd12);
    chk("add_pc", pc_jump_addr, 64'h8000_0004);
    chk("add_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    chk("add_done", {62'b0, in_ready, out_valid}, 64'd2);
    quick("sub", 4'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    quick("xor", 4'd4, 64'hFF00, 64'h0FF0, 64'hF0F0);
    quick("sll_shw", 4'd5, 64'd1, 64'd65, 64'd2);
    quick("srl", 4'd6, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
    quick("sra", 4'd7, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    quick("slt", 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    quick("sltu", 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    long_op("mul", 4'd10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    long_op("div", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    long_op("rem", 4'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    long_op("divu", 4'd12, 64'd100, 64'd7, 64'd14);
    long_op("remu", 4'd14, 64'd100, 64'd7, 64'd2);
    quick("divu_zero", 4'd12, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    quick("rem_zero", 4'd13, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9);
    quick("div_ovf", 4'd11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    quick("rem_ovf", 4'd13, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    out_ready = 1'b0; op1_jump = 64'd1; op2_jump = 64'd2;
    issue(4'd2, 64'hF0F0, 64'hFF00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_state", {62'b0, in_ready, out_valid}, 64'd1);
      chk("hold_rd", rd_data, 64'hF000);
      tick();
    end
    chk("hold_pc", pc_jump_addr, 64'd3);
    out_ready = 1'b1;
    tick();
    chk("hold_release", {62'b0, in_ready, out_valid}, 64'd2);
    issue(4'd12, 64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (19) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_state", {62'b0, in_ready, out_valid}, 64'd2);
    repeat (3) tick();
    chk("flush_no_resp", {63'b0, out_valid}, 64'd0);
    quick("add_after_flush", 4'd0, 64'd3, 64'd4, 64'd7);
    flush = 1'b1; in_op = 4'd0; op1 = 64'd1; op2 = 64'd1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_prio", {62'b0, in_ready, out_valid}, 64'd2);
    issue(4'd15, 64'd5, 64'd6, 1'b1, 1'b0);
    chk("ill_eb_rd", rd_data, 64'd0);
    chk("ill_eb_flags", {61'b0, out_valid, ebreak_o, invalid_o}, 64'd7);
    tick();
    issue(4'd0, 64'd5, 64'd6, 1'b0, 1'b1);
    chk("inv_rd", rd_data, 64'd0);
    chk("inv_flags", {61'b0, out_valid, ebreak_o, invalid_o}, 64'd5);
    tick();
    issue(4'd10, 64'd3, 64'd5, 1'b0, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_rd", rd_data, 64'd0);
    chk("rst_mid_pc", pc_jump_addr, 64'd0);
    chk("rst_mid_state", {60'b0, in_ready, out_valid, ebreak_o, invalid_o}, 64'd8);
    rst = 1'b0;
    tick();
    chk("rst_mid_ready", {62'b0, in_ready, out_valid}, 64'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
